// File: rtl/bsg_mcl_axil_req_arbiter.sv
// Packet-granular round-robin arbiter sharing one host request word stream among num_req_p sources.
// A packet is granted only when downstream vacancy covers all ratio_p words; the locked source then passes through.
module bsg_mcl_axil_req_arbiter #(
  parameter int num_req_p         = 2,
  parameter int axil_data_width_p = 32,
  parameter int ratio_p           = 4,
  parameter int credits_width_p   = 5
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [num_req_p*axil_data_width_p-1:0]     req_data_i,
  input  logic [num_req_p-1:0]                       req_v_i,
  output logic [num_req_p-1:0]                       req_ready_o,
  output logic [axil_data_width_p-1:0]               data_o,
  output logic                                       v_o,
  input  logic                                       ready_i,
  input  logic [credits_width_p-1:0]                 credits_i,
  output logic [((num_req_p>1)?$clog2(num_req_p):1)-1:0] grant_id_o,
  output logic                                       busy_o
);

  localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w_lp = (ratio_p > 1) ? $clog2(ratio_p) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e              state_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic [id_w_lp-1:0]  ptr_q;
  logic [id_w_lp-1:0]  grant_q;

  logic [2*num_req_p-1:0] dbl_v;
  logic [num_req_p-1:0]   rot_v;
  logic                   win_found;
  logic [id_w_lp-1:0]     win_id;
  logic                   credit_ok;
  logic                   hs;
  logic                   last_beat;
  logic [id_w_lp-1:0]     next_ptr;

  // Rotate valids so bit 0 is the source at the round-robin pointer.
  assign dbl_v = {req_v_i, req_v_i} >> ptr_q;
  assign rot_v = dbl_v[num_req_p-1:0];

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!win_found && rot_v[k]) begin
        win_found = 1'b1;
        if (int'(ptr_q) + k >= num_req_p)
          win_id = id_w_lp'(int'(ptr_q) + k - num_req_p);
        else
          win_id = id_w_lp'(int'(ptr_q) + k);
      end
    end
  end

  assign credit_ok = (credits_i >= credits_width_p'(ratio_p));
  assign hs        = (state_q == LOCK) && req_v_i[grant_q] && ready_i;
  assign last_beat = (cnt_q == cnt_w_lp'(ratio_p - 1));
  assign next_ptr  = (grant_q == id_w_lp'(num_req_p - 1)) ? '0 : grant_q + id_w_lp'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found && credit_ok) begin
            grant_q <= win_id;
            cnt_q   <= '0;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          // Credits are not rechecked here: the whole packet was reserved at grant.
          if (hs) begin
            if (last_beat) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              ptr_q   <= next_ptr;
            end else begin
              cnt_q <= cnt_q + cnt_w_lp'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    v_o         = 1'b0;
    req_ready_o = '0;
    data_o      = req_data_i[int'(grant_q)*axil_data_width_p +: axil_data_width_p];
    if (state_q == LOCK) begin
      v_o                  = req_v_i[grant_q];
      req_ready_o[grant_q] = ready_i;
    end
  end

  assign busy_o     = (state_q == LOCK);
  assign grant_id_o = grant_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (num_req_p >= 1);
    assert (ratio_p <= (1 << credits_width_p) - 1);
  end
`endif

endmodule

// File: doc/bsg_mcl_axil_req_arbiter.md
Name: bsg_mcl_axil_req_arbiter

Overview:
- Shares the single host-to-manycore request word stream between num_req_p independent host request sources (for example a DMA engine and an MMIO path).
- Each source delivers request packets as ratio_p consecutive axil_data_width_p-bit words.
- The arbiter locks onto one source for a whole packet, so words from different sources never interleave inside a packet.
- It grants a new packet only when the downstream request buffer reports enough free words for the whole packet. Round-robin fairness is kept at packet granularity.

Parameters:
- num_req_p, 2, number of request sources (2..8).
- axil_data_width_p, 32, width of one request word.
- ratio_p, 4, words per packet (>=1), equal to fifo width / axil data width.
- credits_width_p, 5, width of the downstream free-word count input.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_data_i  in  num_req_p*axil_data_width_p  source words; source i occupies slice i.
- req_v_i  in  num_req_p  per-source valid.
- req_ready_o  out  num_req_p  per-source ready; a word transfers when v & ready.
- data_o  out  axil_data_width_p  granted word to the downstream request buffer.
- v_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- credits_i  in  credits_width_p  downstream free word count (vacancy).
- grant_id_o  out  `BSG_SAFE_CLOG2(num_req_p)  index of the current or last granted source.
- busy_o  out  1  high while a packet is locked.

Behaviour:
- Reset: one clock; reset_i is asynchronous and active-high. While reset is asserted, all of the following are 0:
  - state (IDLE), beat counter, round-robin pointer, grant register;
  - v_o, busy_o, grant_id_o, all req_ready_o.
- Reset asserted mid-packet abandons the packet immediately. No further words are forwarded, and the next packet starts from pointer 0.
- States: IDLE and LOCK, two states only.
- IDLE:
  - v_o=0, all req_ready_o=0, data_o don't-care.
  - Candidates are the sources with req_v_i[i]=1.
  - If there is any candidate AND credits_i >= ratio_p, the winner is the first candidate at or after the pointer, scanning upward with wrap-around (modulo num_req_p).
  - On the next edge: grant register <= winner, beat counter <= 0, state <= LOCK.
  - If credits_i < ratio_p, stay in IDLE with the pointer unchanged, even when candidates exist.
  - Grant latency: at least 1 cycle of IDLE between packets, so the first word is forwarded no earlier than the cycle after the winner is chosen.
- LOCK:
  - Combinational pass-through of the granted source g:
    - data_o = req_data_i slice g;
    - v_o = req_v_i[g];
    - req_ready_o[g] = ready_i;
    - all other req_ready_o = 0.
  - busy_o=1.
  - Beat counter increments on each v_o & ready_i.
  - On the handshake that occurs while the counter equals ratio_p-1:
    - state <= IDLE, counter <= 0;
    - pointer <= (g+1) mod num_req_p.
- Mid-packet stalls: while locked, if the granted source drops valid, the arbiter stays in LOCK and waits. Other sources are never serviced during the lock.
- Credits during LOCK: credits_i is not re-examined, because the whole packet was reserved at grant time. Downstream backpressure (ready_i=0) holds the beat counter.
- ratio_p=1: every packet is a single word. A LOCK lasts until that one handshake, then the FSM returns to IDLE.
- grant_id_o holds its value from the grant register in both states. busy_o is 1 exactly in LOCK.
- Width rules:
  - Beat counter is `BSG_SAFE_CLOG2(ratio_p) bits wide.
  - The credits comparison is unsigned, with ratio_p zero-extended to credits_width_p.
- Simulation-only assertions:
  - num_req_p >= 1;
  - ratio_p <= 2^credits_width_p - 1.

Test Plan:
- Single source: num_req_p=2, ratio_p=4, credits_i=16; source0 presents words 0xA0..0xA3 continuously with ready_i=1.
  - Required: IDLE 1 cycle, then 4 consecutive v_o beats A0,A1,A2,A3.
  - grant_id_o=0, busy_o high for 4 cycles, pointer becomes 1.
- Contention: both sources valid continuously, credits ample.
  - Required: grants alternate 0,1,0,1, with 4 beats each and one IDLE cycle between packets.
  - No interleaving of words from different sources inside a packet.
- Credit gating: credits_i=3 with source1 valid.
  - Required: stays in IDLE, v_o=0, req_ready_o=0.
  - Raising credits_i to 4 produces a grant on the next edge.
- Backpressure and gap: mid-packet, ready_i=0 for 3 cycles, then source valid low for 2 cycles.
  - Required: beat counter holds, the FSM stays in LOCK, the other source's ready stays 0.
  - Exactly 4 handshakes complete the packet.
- Reset mid-packet: assert reset_i asynchronously after beat 2.
  - Required: v_o, busy_o and req_ready_o drop immediately without waiting for a clock edge.
  - After release, arbitration restarts from pointer 0 and source0 wins if valid.
- ratio_p=1, num_req_p=3, all sources valid.
  - Required: single-word packets granted 0,1,2,0, each preceded by one IDLE cycle.
